// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC constants, port indices and arbiter state type
package noc_pkg;

    localparam int PACKET_W = 55;
    localparam int N_PORTS  = 5;

    localparam int EAST  = 0;
    localparam int NORTH = 1;
    localparam int WEST  = 2;
    localparam int SOUTH = 3;
    localparam int LOCAL = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/output_port_arbiter_if.sv
// rtl/output_port_arbiter_if.sv - request/grant and downstream link bundle of the output port arbiter
interface output_port_arbiter_if #(
    parameter int N_PORTS  = noc_pkg::N_PORTS,
    parameter int PACKET_W = noc_pkg::PACKET_W
);

    logic [N_PORTS-1:0]          req;
    logic [N_PORTS*PACKET_W-1:0] packet_in;
    logic [N_PORTS-1:0]          gnt;
    logic [PACKET_W-1:0]         packet_out;
    logic                        out_valid;
    logic                        out_ready;
    logic [2:0]                  grant_idx;
    logic                        busy;
    logic                        timeout_err;

    // arbiter side
    modport master (
        input  req, packet_in, out_ready,
        output gnt, packet_out, out_valid, grant_idx, busy, timeout_err
    );

    // input port controllers and downstream link side
    modport slave (
        output req, packet_in, out_ready,
        input  gnt, packet_out, out_valid, grant_idx, busy, timeout_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting just after last_ptr
module rr_arbiter #(
    parameter int N_PORTS = noc_pkg::N_PORTS
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [2:0]         last_ptr,
    output logic [2:0]         winner,
    output logic               any_req
);

    logic [2*N_PORTS-1:0] req_dbl;
    logic [N_PORTS-1:0]   req_rot;
    logic [3:0]           shamt;
    logic [4:0]           off;
    logic [4:0]           sum;

    assign any_req = |req;
    assign req_dbl = {req, req};
    assign shamt   = 4'(last_ptr) + 4'd1;
    assign req_rot = N_PORTS'(req_dbl >> shamt);

    // rotate so bit 0 is the port after last_ptr, take the lowest set bit, map back
    always_comb begin
        off = '0;
        for (int j = N_PORTS - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                off = 5'(j);
            end
        end
        sum = 5'(last_ptr) + 5'd1 + off;
        if (sum >= 5'(N_PORTS)) begin
            sum = sum - 5'(N_PORTS);
        end
        winner = 3'(sum);
    end

endmodule

// File: rtl/output_port_arbiter.sv
// rtl/output_port_arbiter.sv - round-robin output port arbiter; ARB_TIMEOUT_EN adds a SEND watchdog
module output_port_arbiter
    import noc_pkg::*;
#(
    parameter int N_PORTS     = noc_pkg::N_PORTS,
    parameter int PACKET_W    = noc_pkg::PACKET_W,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    output_port_arbiter_if.master bus
);

    arb_state_e          state_q, state_d;
    logic [2:0]          grant_idx_q, grant_idx_d;
    logic [2:0]          last_ptr_q, last_ptr_d;
    logic [PACKET_W-1:0] packet_out_q, packet_out_d;
    logic [2:0]          winner;
    logic                any_req;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_err_q, timeout_err_d;
`else
    localparam int timeout_cyc_unused = TIMEOUT_CYC;
`endif

    rr_arbiter #(.N_PORTS(N_PORTS)) u_rr (
        .req      (bus.req),
        .last_ptr (last_ptr_q),
        .winner   (winner),
        .any_req  (any_req)
    );

    // next-state: the winner is frozen in IDLE, so GRANT captures even if req drops
    always_comb begin
        state_d      = state_q;
        grant_idx_d  = grant_idx_q;
        last_ptr_d   = last_ptr_q;
        packet_out_d = packet_out_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_idx_d = winner;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                for (int i = 0; i < N_PORTS; i++) begin
                    if (grant_idx_q == 3'(i)) begin
                        packet_out_d = bus.packet_in[i*PACKET_W +: PACKET_W];
                    end
                end
                last_ptr_d = grant_idx_q;
                state_d    = SEND;
`ifdef ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            SEND: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_idx_q  <= '0;
            last_ptr_q   <= 3'(N_PORTS - 1);
            packet_out_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_idx_q  <= grant_idx_d;
            last_ptr_q   <= last_ptr_d;
            packet_out_q <= packet_out_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // watchdog counter and drop pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    // one-hot grant decode, only during GRANT
    always_comb begin
        bus.gnt = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            bus.gnt[i] = (state_q == GRANT) && (grant_idx_q == 3'(i));
        end
    end

    assign bus.out_valid  = (state_q == SEND);
    assign bus.busy       = (state_q != IDLE);
    assign bus.packet_out = packet_out_q;
    assign bus.grant_idx  = grant_idx_q;

endmodule
